// File: rtl/mem_aw_issuer.sv
// mem_aw_issuer: queues 4K-safe write requests and issues them as AXI4 AW bursts plus
// beat-count descriptors, tracking outstanding bursts. Optional checks: MEM_AW_ISSUER_ERR_CHECK_EN.
module mem_aw_issuer #(
    parameter int ADDR_WIDTH      = 64,
    parameter int REQ_SIZE_WIDTH  = 16,
    parameter int BEAT_BYTES      = 64,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [REQ_SIZE_WIDTH-1:0] req_size_bytes,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic [7:0]                wlen_data,
    output logic                      wlen_valid,
    input  logic                      wlen_ready,
    output logic                      idle,
    output logic                      err_overflow,
    output logic                      err_bresp,
    output logic                      err_size
);
    localparam int BB_LOG2 = $clog2(BEAT_BYTES);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W  = REQ_SIZE_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_addr [FIFO_DEPTH];
    logic [7:0]            r_len  [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_aw_done, r_wl_done;
    logic [OUT_W-1:0]      r_out;
    logic                  r_bready, r_err_overflow;

    logic             w_empty, w_full, w_aw_hs, w_wl_hs, w_b_hs, w_b_dec, w_pop, w_push;
    logic [BEAT_W-1:0] w_beats;

    // Size 0 is treated as a single beat so awlen never wraps to 255.
    function automatic logic [BEAT_W-1:0] beats_of(input logic [REQ_SIZE_WIDTH-1:0] size);
        logic [BEAT_W-1:0] sum;
        sum = {1'b0, size} + BEAT_W'(BEAT_BYTES - 1);
        return (size == '0) ? BEAT_W'(1) : (sum >> BB_LOG2);
    endfunction

    assign w_beats = beats_of(req_size_bytes);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_aw_hs = m_awvalid & m_awready;
    assign w_wl_hs = wlen_valid & wlen_ready;
    assign w_b_hs  = m_bvalid & r_bready;
    assign w_b_dec = w_b_hs & (r_out != '0);
    assign w_pop   = !w_empty & (r_aw_done | w_aw_hs) & (r_wl_done | w_wl_hs);
    assign w_push  = req_valid & (!w_full | w_pop);

    assign m_awvalid    = !w_empty & !r_aw_done & (r_out < OUT_W'(MAX_OUTSTANDING));
    assign wlen_valid   = !w_empty & !r_wl_done;
    assign m_awaddr     = r_addr[r_rptr];
    assign m_awlen      = r_len[r_rptr];
    assign wlen_data    = r_len[r_rptr];
    assign m_awsize     = 3'(BB_LOG2);
    assign m_awburst    = 2'b01;
    assign m_bready     = r_bready;
    assign req_ready    = (r_count <= CNT_W'(FIFO_DEPTH - 2));
    assign idle         = w_empty & (r_out == '0);
    assign err_overflow = r_err_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= req_addr;
            r_len[r_wptr]  <= 8'(w_beats - BEAT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_aw_done      <= 1'b0;
            r_wl_done      <= 1'b0;
            r_out          <= '0;
            r_bready       <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_bready <= 1'b1;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_aw_done <= 1'b0;
                r_wl_done <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_wl_hs) r_wl_done <= 1'b1;
            end
            // A B response with nothing outstanding is ignored rather than underflowing.
            case ({w_aw_hs, w_b_dec})
                2'b10:   r_out <= r_out + OUT_W'(1);
                2'b01:   r_out <= r_out - OUT_W'(1);
                default: r_out <= r_out;
            endcase
            if (req_valid && w_full && !w_pop) r_err_overflow <= 1'b1;
        end
    end

`ifdef MEM_AW_ISSUER_ERR_CHECK_EN
    logic r_err_bresp, r_err_size;
    logic w_size_bad;

    assign w_size_bad = (req_size_bytes == '0)
                      || ((req_size_bytes & REQ_SIZE_WIDTH'(BEAT_BYTES - 1)) != '0)
                      || (32'(w_beats) > 32'd256);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_bresp <= 1'b0;
            r_err_size  <= 1'b0;
        end else begin
            if (w_b_hs && (m_bresp != 2'b00)) r_err_bresp <= 1'b1;
            if (w_push && w_size_bad)         r_err_size  <= 1'b1;
        end
    end

    assign err_bresp = r_err_bresp;
    assign err_size  = r_err_size;
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^m_bresp;
    assign err_bresp      = 1'b0;
    assign err_size       = 1'b0;
`endif

endmodule

// File: doc/mem_aw_issuer.md
# mem_aw_issuer

Downstream stage of the memory request splitter. It accepts each 4K-safe write request (address plus byte count) into a small FIFO and converts it to an AXI4 AW-channel burst. In parallel it emits a beat-count descriptor to the write-data stage and tracks outstanding bursts against B responses. It also produces the ready signal the splitter waits on before issuing each sub-request.

## Interface
- ADDR_WIDTH, 64, request/AXI address width
- REQ_SIZE_WIDTH, 16, request byte-count width
- BEAT_BYTES, 64, bytes per AXI data beat (power of 2, 1..128)
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2)
- MAX_OUTSTANDING, 16, maximum AW-issued bursts still awaiting a B response (≥1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_addr  in  ADDR_WIDTH  request start address
- req_size_bytes  in  REQ_SIZE_WIDTH  request length in bytes
- req_valid  in  1  single-cycle request strobe (no backpressure at source)
- req_ready  out  1  ≥2 free FIFO entries; feeds the splitter's axi_wr_ready
- m_awaddr  out  ADDR_WIDTH  AXI AWADDR
- m_awlen  out  8  AXI AWLEN
- m_awsize  out  3  constant log2(BEAT_BYTES)
- m_awburst  out  2  constant 2'b01 (INCR)
- m_awvalid  out  1  AXI AWVALID
- m_awready  in  1  AXI AWREADY
- m_bvalid  in  1  AXI BVALID
- m_bresp  in  2  AXI BRESP
- m_bready  out  1  AXI BREADY
- wlen_data  out  8  beats−1 for the write-data stage
- wlen_valid  out  1  descriptor valid
- wlen_ready  in  1  descriptor accepted
- idle  out  1  FIFO empty and zero outstanding
- err_overflow  out  1  sticky: req_valid arrived while FIFO full and no same-cycle pop
- err_bresp  out  1  sticky: B handshake with BRESP≠0 (macro only)
- err_size  out  1  sticky: bad request size (macro only)

## Operation
- Push: req_valid writes {addr, awlen} at the tail.
  - awlen = ceil(size/BEAT_BYTES)−1, truncated to 8 bits.
  - size 0 gives awlen 0.
- A push while full with a simultaneous head pop is accepted. A push while full without a pop is dropped and sets err_overflow.
- Head entry states: PEND, then one or both of AW_DONE / WL_DONE, then POP.
  - Two flags, aw_done and wl_done, track the head entry.
  - m_awvalid = !empty & !aw_done & (outstanding < MAX_OUTSTANDING).
  - wlen_valid = !empty & !wl_done.
  - Each handshake sets its flag. The entry pops on the cycle the last pending handshake completes, and both flags clear.
  - Both handshakes in the same cycle pop immediately.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on AW handshake, −1 on B handshake; both in the same cycle leave it unchanged.
  - A B handshake with the counter at 0 is ignored (no underflow).
- m_bready is a register: reset 0, then 1 from the first clock after reset deasserts.
- idle = empty & (outstanding == 0).
- req_ready = (count ≤ FIFO_DEPTH−2). The one-entry slack absorbs the splitter's one-cycle ready-to-valid lag.

## Timing
- All outputs are registered or decoded from registers only; there are no input-to-output combinational paths.
- Reset values:
  - req_ready 1, idle 1
  - m_awvalid 0, wlen_valid 0, m_bready 0
  - all error flags 0, counters and pointers 0
- Latency: req_valid in cycle N gives m_awvalid and wlen_valid in N+1 (empty FIFO, outstanding below limit).
- m_awaddr, m_awlen and wlen_data hold stable while their valid is high and unacknowledged.
- With m_awready and wlen_ready held high, the issue rate is one burst per cycle.
- An AW-limit stall does not block the wlen descriptor.
- Reset asserted mid-operation: queued entries and outstanding count are discarded; outputs return to reset values asynchronously.

## Configuration
- MEM_AW_ISSUER_ERR_CHECK_EN defined:
  - err_bresp sets on any B handshake with m_bresp≠2'b00.
  - err_size sets on push when size==0, when size is not a multiple of BEAT_BYTES, or when ceil(size/BEAT_BYTES) > 256.
  - The request is still queued.
- Undefined: err_bresp and err_size are tied 0, with no check logic.

## Test plan
- Single request: addr 0x1000, size 256, BEAT_BYTES 64, awready/wlen_ready high → awvalid one cycle after req_valid, awaddr 0x1000, awlen 3, wlen_data 3, entry pops; after B, idle=1.
- Backpressure split: awready low 5 cycles, wlen_ready high → wlen accepted immediately, awvalid held with stable awaddr; pop only on the AW handshake.
- Outstanding limit (MAX_OUTSTANDING 2, bvalid low): 3 requests → third awvalid stays 0 until one B handshake, then issues the next cycle.
- Flow control: awready low, 4 pushes → req_ready drops after the 3rd. A 5th push while full sets err_overflow and is dropped; the 4 queued entries drain in order.
- Errors (macro on): size 100 → err_size=1, awlen 1. B with bresp=2'b10 → err_bresp=1. Macro off: both stay 0.
- Reset mid-op: assert reset with 2 queued and 3 outstanding → awvalid 0 and idle 1 immediately; after release, a new request issues normally.
